// File: rtl/add_pipe_32_pkg.sv
// Shared widths, saturation limits and carry-lookahead helpers for the add_pipe_32 slice.
// Pure constants/functions: no state, no latency, no flow control.
// Used by both the pipeline top and the 16-bit CLA half-adder.
package add_pipe_32_pkg;

    localparam int ADD_HALF_W = 16;
    localparam int ADD_FULL_W = 32;

    localparam logic [ADD_FULL_W-1:0] ADD_SMAX = 32'h7FFF_FFFF;
    localparam logic [ADD_FULL_W-1:0] ADD_SMIN = 32'h8000_0000;

    // Carry into each bit of a 4-bit group, bit 0 being the group carry-in.
    function automatic logic [3:0] carry4(input logic [3:0] g, input logic [3:0] p, input logic cin);
        logic [3:0] c;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

    function automatic logic grp_g(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

endpackage

// File: rtl/add_pipe_32_cla16.sv
// 16-bit two-level carry-lookahead adder exposing group propagate/generate.
// Latency: purely combinational.
// Backpressure: none; the enclosing pipeline owns all flow control.
module add_pipe_32_cla16
    import add_pipe_32_pkg::*;
(
    input  logic [ADD_HALF_W-1:0] A,
    input  logic [ADD_HALF_W-1:0] B,
    input  logic                  c0,
    output logic [ADD_HALF_W-1:0] S,
    output logic                  px,
    output logic                  gx
);

    logic [ADD_HALF_W-1:0] p;
    logic [ADD_HALF_W-1:0] g;
    logic [ADD_HALF_W-1:0] c;
    logic [3:0]            gp;
    logic [3:0]            gg;
    logic [3:0]            gc;

    assign p = A ^ B;
    assign g = A & B;

    for (genvar k = 0; k < 4; k++) begin : g_grp
        assign gp[k]       = &p[4*k +: 4];
        assign gg[k]       = grp_g(g[4*k +: 4], p[4*k +: 4]);
        assign c[4*k +: 4] = carry4(g[4*k +: 4], p[4*k +: 4], gc[k]);
    end

    // Second lookahead level resolves the carry into each 4-bit group.
    assign gc = carry4(gg, gp, c0);

    assign S  = p ^ c;
    assign px = &gp;
    assign gx = grp_g(gg, gp);

endmodule

// File: rtl/add_pipe_32.sv
// Two-stage 32-bit adder: low half + carry in stage 1, high half into output register. Option: ADD_PIPE_SAT_EN.
// Latency: 2 cycles from input transfer to out_valid, one result per cycle.
// Backpressure: output holds while !out_ready, stage 1 fills, then in_ready drops.
module add_pipe_32
    import add_pipe_32_pkg::*;
#(
    parameter int W_HALF = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADD_FULL_W-1:0] A,
    input  logic [ADD_FULL_W-1:0] B,
    input  logic                  c0,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADD_FULL_W-1:0] S,
    output logic                  c32,
    output logic                  ovf
);

    if (W_HALF != ADD_HALF_W) begin : g_bad_w_half
        $error("add_pipe_32: W_HALF must be 16");
    end

    logic                  s1_valid;
    logic [ADD_HALF_W-1:0] s1_s_lo;
    logic                  s1_c16;
    logic [ADD_HALF_W-1:0] s1_a_hi;
    logic [ADD_HALF_W-1:0] s1_b_hi;

    logic                  s1_adv;
    logic                  in_xfer;

    logic [ADD_HALF_W-1:0] lo_s;
    logic                  lo_px;
    logic                  lo_gx;
    logic                  c16_d;

    logic [ADD_HALF_W-1:0] hi_s;
    logic                  hi_px;
    logic                  hi_gx;
    logic                  c32_d;
    logic                  ovf_d;
    logic [ADD_FULL_W-1:0] sum_d;
    logic [ADD_FULL_W-1:0] s_d;

    assign s1_adv   = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~rst & (~s1_valid | s1_adv);
    assign in_xfer  = in_valid & in_ready;

    add_pipe_32_cla16 u_cla_lo (
        .A  (A[ADD_HALF_W-1:0]),
        .B  (B[ADD_HALF_W-1:0]),
        .c0 (c0),
        .S  (lo_s),
        .px (lo_px),
        .gx (lo_gx)
    );

    assign c16_d = lo_gx | (lo_px & c0);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_s_lo  <= '0;
            s1_c16   <= 1'b0;
            s1_a_hi  <= '0;
            s1_b_hi  <= '0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_s_lo  <= lo_s;
            s1_c16   <= c16_d;
            s1_a_hi  <= A[ADD_FULL_W-1:ADD_HALF_W];
            s1_b_hi  <= B[ADD_FULL_W-1:ADD_HALF_W];
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    add_pipe_32_cla16 u_cla_hi (
        .A  (s1_a_hi),
        .B  (s1_b_hi),
        .c0 (s1_c16),
        .S  (hi_s),
        .px (hi_px),
        .gx (hi_gx)
    );

    assign c32_d = hi_gx | (hi_px & s1_c16);
    assign sum_d = {hi_s, s1_s_lo};
    assign ovf_d = (s1_a_hi[ADD_HALF_W-1] == s1_b_hi[ADD_HALF_W-1])
                 & (hi_s[ADD_HALF_W-1] != s1_a_hi[ADD_HALF_W-1]);

`ifdef ADD_PIPE_SAT_EN
    // Clamp toward the sign of the operands; c32 still reports the raw carry.
    assign s_d = ovf_d ? (s1_a_hi[ADD_HALF_W-1] ? ADD_SMIN : ADD_SMAX) : sum_d;
`else
    assign s_d = sum_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            S         <= '0;
            c32       <= 1'b0;
            ovf       <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            S         <= s_d;
            c32       <= c32_d;
            ovf       <= ovf_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add_pipe_32.sv
// Self-checking bench for add_pipe_32: directed corner cases plus randomized handshake traffic
// scored against an arithmetic reference queue.
module tb_add_pipe_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        c0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] S;
    logic        c32;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;

    // Expected {c32, ovf, S} for every accepted operand set, oldest first.
    logic [33:0] q[$];

    always #5 clk = ~clk;

    add_pipe_32 #(.W_HALF(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .c0        (c0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .c32       (c32),
        .ovf       (ovf)
    );

    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic c);
        logic [32:0] t;
        logic [31:0] s;
        logic        o;
        t = {1'b0, a} + {1'b0, b} + {32'd0, c};
        s = t[31:0];
        o = (a[31] == b[31]) && (s[31] != a[31]);
`ifdef ADD_PIPE_SAT_EN
        if (o) s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {t[32], o, s};
    endfunction

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: checks every output transfer and output stability under backpressure.
    initial begin
        logic        hold;
        logic [34:0] held;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                hold = 1'b0;
                chk("in_ready_in_reset", {39'd0, in_ready}, 40'd0);
            end else begin
                if (hold)
                    chk("hold_stable", {5'd0, out_valid, c32, ovf, S}, {5'd0, held});
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL spurious_output: got S=%h with nothing outstanding at %0t", S, $time);
                    end else begin
                        chk("result", {6'd0, c32, ovf, S}, {6'd0, q.pop_front()});
                    end
                end
                if (in_valid && in_ready)
                    q.push_back(model(A, B, c0));
                hold = out_valid && !out_ready;
                held = {out_valid, c32, ovf, S};
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Single operand through an empty pipeline with out_ready=1, checking the 2-cycle latency.
    task automatic direct(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic [31:0] es, input logic ec, input logic eo, input string nm);
        A = a; B = b; c0 = c; in_valid = 1'b1;
        chk({nm, "_in_ready"}, {39'd0, in_ready}, 40'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({nm, "_not_early"}, {39'd0, out_valid}, 40'd0);
        chk({nm, "_in_ready_mid"}, {39'd0, in_ready}, 40'd1);
        @(posedge clk); #1;
        chk({nm, "_valid"}, {39'd0, out_valid}, 40'd1);
        chk({nm, "_value"}, {6'd0, ec, eo, es}, {6'd0, c32, ovf, S});
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] exp_sat;
        int          mode;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; c0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {5'd0, out_valid, c32, ovf, S}, 40'd0);
        chk("reset_in_ready", {39'd0, in_ready}, 40'd0);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("in_ready_after_reset", {39'd0, in_ready}, 40'd1);
        @(posedge clk); #1;

        direct(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, "half_carry");
        direct(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "c16_ripple");
`ifdef ADD_PIPE_SAT_EN
        exp_sat = 32'h7FFF_FFFF;
`else
        exp_sat = 32'h8000_0000;
`endif
        direct(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, exp_sat, 1'b0, 1'b1, "pos_ovf");

        // Back-to-back stream: a result every cycle once the pipe is full.
        for (int i = 0; i < 8; i++) begin
            A = i; B = i * 3; c0 = 1'b0; in_valid = 1'b1;
            chk("stream_in_ready", {39'd0, in_ready}, 40'd1);
            if (i >= 2)
                chk("stream_out", {7'd0, out_valid, S}, {7'd0, 1'b1, 32'((i - 2) * 4)});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int j = 0; j < 2; j++) begin
            chk("stream_tail", {7'd0, out_valid, S}, {7'd0, 1'b1, 32'((6 + j) * 4)});
            @(posedge clk); #1;
        end
        chk("stream_empty", {39'd0, out_valid}, 40'd0);

        // Backpressure: output stalls, stage 1 fills, in_ready drops.
        out_ready = 1'b0;
        A = 32'd100; B = 32'd1; in_valid = 1'b1;
        chk("bp_accept1", {39'd0, in_ready}, 40'd1);
        @(posedge clk); #1;
        A = 32'd200; B = 32'd2;
        chk("bp_accept2", {39'd0, in_ready}, 40'd1);
        @(posedge clk); #1;
        A = 32'd300; B = 32'd3;
        for (int j = 0; j < 3; j++) begin
            chk("bp_in_ready_low", {39'd0, in_ready}, 40'd0);
            chk("bp_out_held", {7'd0, out_valid, S}, {7'd0, 1'b1, 32'd101});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {39'd0, in_ready}, 40'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_no_loss", {8'd0, 32'(q.size())}, 40'd0);
        chk("bp_drained", {39'd0, out_valid}, 40'd0);

        // Reset with two operands in flight: nothing stale may come out.
        out_ready = 1'b0;
        A = 32'd11; B = 32'd22; in_valid = 1'b1;
        @(posedge clk); #1;
        A = 32'd33; B = 32'd44;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        #1;
        chk("rst_in_ready", {39'd0, in_ready}, 40'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_cleared", {39'd0, out_valid}, 40'd0);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            chk("rst_no_stale", {39'd0, out_valid}, 40'd0);
        end
        direct(32'd5, 32'd7, 1'b0, 32'd12, 1'b0, 1'b0, "post_rst");

        // Randomized traffic on both handshakes, with operands biased toward carry/overflow edges.
        for (int n = 0; n < 10000; n++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 70);
            mode = $urandom_range(0, 3);
            A  = $urandom;
            B  = $urandom;
            c0 = $urandom_range(0, 1);
            if (mode == 1) begin
                A = {A[31], 15'h7FFF, 16'hFFFF};
                B = {B[31], 31'd0} | {16'd0, B[15:0]};
            end else if (mode == 2) begin
                A[15:0] = 16'hFFFF;
                B[15:0] = 16'd0;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int j = 0; j < 20 && q.size() != 0; j++) begin
            @(posedge clk); #1;
        end
        chk("random_drain", {8'd0, 32'(q.size())}, 40'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
